// File: rtl/glow_ram_array.sv
`default_nettype none
// glow_ram_array: NUM_WORDS x WIDTH glow-sticker RAM with host req/ack handshake and background refresh.
// Rev 1.0 - initial release
module glow_ram_array #(
    parameter int WIDTH          = 8,
    parameter int NUM_WORDS      = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int CHARGE_CYCLES  = 1000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int REFRESH_CYCLES = 100000,
    parameter int REFRESH_EN     = 1,
    parameter int INVERT_SENSE   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       we,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       ack,
    output logic                       busy,
    output logic [NUM_WORDS*WIDTH-1:0] glow_leds,
    input  logic [NUM_WORDS*WIDTH-1:0] glow_value,
    output logic [2:0]                 debug_state,
    output logic [ADDR_WIDTH-1:0]      refresh_addr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int TOTAL     = NUM_WORDS * WIDTH;
    localparam int MAX_PHASE = (CHARGE_CYCLES > SETTLE_CYCLES) ? CHARGE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int TMR_W     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [CNT_W-1:0]      CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]      TMR_LAST    = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD   = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [WIDTH-1:0]      SENSE_MASK  = (INVERT_SENSE != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  pending_q, pending_d;
    logic                  is_refresh_q, is_refresh_d;
    logic [ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
    logic [ADDR_WIDTH-1:0] rfsh_addr_q, rfsh_addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0]      rfsh_data_q, rfsh_data_d;
    logic                  ack_q, ack_d;
    logic [TOTAL-1:0]      leds_q, leds_d;
    logic [TOTAL-1:0]      sync1_q, sync1_d;
    logic [TOTAL-1:0]      sync2_q, sync2_d;

    logic [TOTAL-1:0]      sensed;
    logic [WIDTH-1:0]      sel_word;
    logic [WIDTH-1:0]      charge_word;

    assign sync1_d = glow_value;
    assign sync2_d = sync1_q;
    assign sensed  = sync2_q ^ {NUM_WORDS{SENSE_MASK}};

    // Out-of-range addresses match no word and therefore read back as zero.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (op_addr_q == ADDR_WIDTH'(i)) begin
                sel_word = sensed[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        is_refresh_d = is_refresh_q;
        op_addr_d    = op_addr_q;
        rfsh_addr_d  = rfsh_addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rfsh_data_d  = rfsh_data_q;
        ack_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d    = 1'b0;
                    is_refresh_d = 1'b1;
                    op_addr_d    = rfsh_addr_q;
                    cnt_d        = '0;
                    state_d      = ST_SETTLE;
                end else if (req) begin
                    is_refresh_d = 1'b0;
                    op_addr_d    = addr;
                    wdata_d      = wdata;
                    cnt_d        = '0;
                    state_d      = we ? ST_CHARGE : ST_SETTLE;
                end
            end
            ST_CHARGE: begin
                if (cnt_q == CHARGE_LAST) begin
                    state_d = ST_DONE;
                    ack_d   = ~is_refresh_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                cnt_d = '0;
                if (is_refresh_q) begin
                    rfsh_data_d = sel_word;
                    state_d     = ST_CHARGE;
                end else begin
                    rdata_d = sel_word;
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (is_refresh_q) begin
                    rfsh_addr_d = (rfsh_addr_q == LAST_WORD) ? '0 : rfsh_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Evaluated after arbitration so a wrap in the acceptance cycle is not lost.
        if (REFRESH_EN != 0) begin
            if (timer_q == TMR_LAST) begin
                timer_d   = '0;
                pending_d = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end else begin
            timer_d   = '0;
            pending_d = 1'b0;
        end
    end

    // LED drive is derived from next-state values so the registered output lines up with CHARGE.
    always_comb begin
        charge_word = is_refresh_d ? rfsh_data_d : wdata_d;
        leds_d      = '0;
        if (state_d == ST_CHARGE) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (op_addr_d == ADDR_WIDTH'(i)) begin
                    leds_d[i*WIDTH +: WIDTH] = charge_word;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            is_refresh_q <= 1'b0;
            op_addr_q    <= '0;
            rfsh_addr_q  <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rfsh_data_q  <= '0;
            ack_q        <= 1'b0;
            leds_q       <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            is_refresh_q <= is_refresh_d;
            op_addr_q    <= op_addr_d;
            rfsh_addr_q  <= rfsh_addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rfsh_data_q  <= rfsh_data_d;
            ack_q        <= ack_d;
            leds_q       <= leds_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
        end
    end

    assign rdata        = rdata_q;
    assign ack          = ack_q;
    assign busy         = (state_q != ST_IDLE);
    assign glow_leds    = leds_q;
    assign debug_state  = state_q;
    assign refresh_addr = rfsh_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_glow_ram_array.sv
`default_nettype none
// tb_glow_ram_array: directed vector table plus hand-written refresh, arbitration and reset sequences.
// Rev 1.0 - initial release
module tb_glow_ram_array;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic [7:0]  exp_rdata_inv;
        logic [23:0] exp_leds;
        int          exp_lat;
        int          exp_led_cyc;
    } vec_t;

    localparam logic [23:0] GLOW_A  = 24'h3C5A00;
    localparam logic [23:0] PRELOAD = 24'h332211;

    logic        clk;
    logic        rst_a_n, rst_b_n;
    logic        req_a, we_a, req_b, we_b;
    logic [1:0]  addr_a, addr_b;
    logic [7:0]  wdata_a, wdata_b;
    logic [7:0]  rdata_a, rdata_c, rdata_b;
    logic        ack_a, ack_c, ack_b;
    logic        busy_a, busy_c, busy_b;
    logic [23:0] glow_leds_a, glow_leds_c, glow_leds_b;
    logic [23:0] glow_value_a, glow_value_b;
    logic [2:0]  dbg_a, dbg_c, dbg_b;
    logic [1:0]  raddr_a, raddr_c, raddr_b;

    int n_err = 0;
    int n_checks = 0;
    int ack_cnt_b = 0;
    int cell_cnt [24];
    vec_t vecs [8];

    glow_ram_array #(.WIDTH(8), .NUM_WORDS(3), .ADDR_WIDTH(2), .CHARGE_CYCLES(4), .SETTLE_CYCLES(2),
                     .REFRESH_CYCLES(50), .REFRESH_EN(0), .INVERT_SENSE(0)) dut_a (
        .clk(clk), .reset(rst_a_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .glow_leds(glow_leds_a),
        .glow_value(glow_value_a), .debug_state(dbg_a), .refresh_addr(raddr_a));

    glow_ram_array #(.WIDTH(8), .NUM_WORDS(3), .ADDR_WIDTH(2), .CHARGE_CYCLES(4), .SETTLE_CYCLES(2),
                     .REFRESH_CYCLES(50), .REFRESH_EN(0), .INVERT_SENSE(1)) dut_c (
        .clk(clk), .reset(rst_a_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_c), .ack(ack_c), .busy(busy_c), .glow_leds(glow_leds_c),
        .glow_value(glow_value_a), .debug_state(dbg_c), .refresh_addr(raddr_c));

    glow_ram_array #(.WIDTH(8), .NUM_WORDS(3), .ADDR_WIDTH(2), .CHARGE_CYCLES(4), .SETTLE_CYCLES(2),
                     .REFRESH_CYCLES(50), .REFRESH_EN(1), .INVERT_SENSE(0)) dut_b (
        .clk(clk), .reset(rst_b_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .glow_leds(glow_leds_b),
        .glow_value(glow_value_b), .debug_state(dbg_b), .refresh_addr(raddr_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign glow_value_a = GLOW_A;

    // Glowing cells: a lit LED recharges its cell; an unlit cell fades after a fixed time.
    always @(posedge clk) begin
        for (int i = 0; i < 24; i++) begin
            if (!rst_b_n)              cell_cnt[i] <= PRELOAD[i] ? 400 : 0;
            else if (glow_leds_b[i])   cell_cnt[i] <= 200;
            else if (cell_cnt[i] > 0)  cell_cnt[i] <= cell_cnt[i] - 1;
        end
    end

    always_comb begin
        glow_value_b = '0;
        for (int i = 0; i < 24; i++) glow_value_b[i] = (cell_cnt[i] > 0);
    end

    always @(negedge clk) if (ack_b === 1'b1) ack_cnt_b <= ack_cnt_b + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, busy_cnt, led_cyc, led_bad;
        lat = -1; busy_cnt = 0; led_cyc = 0; led_bad = 0;
        @(posedge clk); #1;
        req_a = 1'b1; we_a = v.we; addr_a = v.addr; wdata_a = v.wdata;
        for (int k = 0; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
            if (glow_leds_a != 24'h0) begin
                led_cyc++;
                if (glow_leds_a != v.exp_leds) led_bad++;
            end
            if (ack_a) begin
                lat = k;
                req_a = 1'b0;
            end
        end
        req_a = 1'b0;
        check({tag, "_ack_latency"}, lat, v.exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, v.exp_lat);
        check({tag, "_led_cycles"}, led_cyc, v.exp_led_cyc);
        check({tag, "_led_pattern_bad"}, led_bad, 0);
        check({tag, "_rdata"}, rdata_a, v.exp_rdata);
        check({tag, "_rdata_inv"}, rdata_c, v.exp_rdata_inv);
        @(negedge clk);
        check({tag, "_ack_one_cycle"}, ack_a, 1'b0);
        check({tag, "_busy_after"}, busy_a, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, found, acks;
        logic [23:0] exp_rf [4];
        logic [1:0]  exp_wd [4];
        vec_t rd2;

        vecs[0] = '{1'b1, 2'd1, 8'hA5, 8'h00, 8'h00, 24'h00A500, 5, 4};
        vecs[1] = '{1'b0, 2'd2, 8'h00, 8'h3C, 8'hC3, 24'h000000, 4, 0};
        vecs[2] = '{1'b1, 2'd2, 8'h00, 8'h3C, 8'hC3, 24'h000000, 5, 0};
        vecs[3] = '{1'b0, 2'd3, 8'h00, 8'h00, 8'h00, 24'h000000, 4, 0};
        vecs[4] = '{1'b1, 2'd3, 8'hFF, 8'h00, 8'h00, 24'h000000, 5, 0};
        vecs[5] = '{1'b0, 2'd1, 8'h00, 8'h5A, 8'hA5, 24'h000000, 4, 0};
        vecs[6] = '{1'b1, 2'd0, 8'h81, 8'h5A, 8'hA5, 24'h000081, 5, 4};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'hFF, 24'h000000, 4, 0};
        exp_rf[0] = 24'h000011; exp_rf[1] = 24'h002200; exp_rf[2] = 24'h330000; exp_rf[3] = 24'h000011;
        exp_wd[0] = 2'd0; exp_wd[1] = 2'd1; exp_wd[2] = 2'd2; exp_wd[3] = 2'd0;

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_leds_a", glow_leds_a, 24'h0);
        check("reset_ack_a", ack_a, 1'b0);
        check("reset_busy_a", busy_a, 1'b0);
        check("reset_rdata_a", rdata_a, 8'h00);
        check("reset_state_a", dbg_a, 3'd0);
        check("reset_leds_b", glow_leds_b, 24'h0);
        check("reset_raddr_b", raddr_b, 2'd0);
        check("reset_busy_b", busy_b, 1'b0);
        @(posedge clk); #1 rst_a_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table: writes, reads, inverted sensing, out-of-range addresses, rdata hold.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset pulsed in the middle of a write's CHARGE phase.
        @(posedge clk); #1;
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 8'hFF;
        @(posedge clk); @(posedge clk); #1;
        req_a = 1'b0;
        #2;
        check("midreset_charging", glow_leds_a, 24'h0000FF);
        rst_a_n = 1'b0;
        #1;
        check("midreset_leds", glow_leds_a, 24'h0);
        check("midreset_busy", busy_a, 1'b0);
        check("midreset_ack", ack_a, 1'b0);
        check("midreset_state", dbg_a, 3'd0);
        @(posedge clk); @(posedge clk); #1 rst_a_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        check("midreset_no_ack", acks, 0);
        rd2 = '{1'b0, 2'd2, 8'h00, 8'h3C, 8'hC3, 24'h000000, 4, 0};
        run_vec(rd2, "post_reset_read");

        // Refresh engine: visits 0,1,2,0 and recharges each word's own pattern.
        @(posedge clk); #1 rst_b_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            found = 0;
            for (int k = 0; k < 200 && found == 0; k++) begin
                @(negedge clk);
                if (glow_leds_b != 24'h0) found = 1;
            end
            check($sformatf("refresh%0d_seen", r), found, 1);
            check($sformatf("refresh%0d_pattern", r), glow_leds_b, exp_rf[r]);
            check($sformatf("refresh%0d_addr", r), raddr_b, exp_wd[r]);
            cnt = 0;
            for (int k = 0; k < 20 && glow_leds_b != 24'h0; k++) begin
                cnt++;
                @(negedge clk);
            end
            check($sformatf("refresh%0d_charge_len", r), cnt, 4);
            @(negedge clk);
            check($sformatf("refresh%0d_next_addr", r), raddr_b, (r + 1) % 3);
        end
        check("refresh_no_ack", ack_cnt_b, 0);

        // Host request arriving in the same cycle as a pending refresh.
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            if (busy_b) found = 1;
        end
        check("arb_refresh_start_seen", found, 1);
        repeat (49) @(posedge clk);
        #1;
        req_b = 1'b1; we_b = 1'b0; addr_b = 2'd1; wdata_b = 8'h00;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) check("arb_idle_at_req", busy_b, 1'b0);
            if (k == 1) check("arb_refresh_first", busy_b, 1'b1);
            if (k == 4) check("arb_refresh_word2", glow_leds_b, 24'h330000);
            if (k == 9) check("arb_idle_between", busy_b, 1'b0);
            if (ack_b && lat < 0) begin
                lat = k;
                req_b = 1'b0;
                check("arb_read_rdata", rdata_b, 8'h22);
            end
        end
        req_b = 1'b0;
        check("arb_ack_latency", lat, 13);
        check("arb_single_ack", ack_cnt_b, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
